uart_io_ctrl: RTL and testbench

- Controller between the CPU-side UART strobes and a byte-level UART TX/RX core.
- Buffers CPU writes in a TX FIFO and drains it to the TX core with a valid/ready handshake.
- Holds one received byte for the CPU and tracks overrun.
- Produces the 4-bit status word the CPU polls through the misc.in IO port.

---
 rtl/uart_io_pkg.sv | 21 ++
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_io_ctrl.sv | 115 +++++++++++
 tb/tb_uart_io_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_io_pkg.sv
// Shared definitions for the UART IO controller: status bit layout, default
// FIFO size, RX holder state encoding and a saturating increment helper.
package uart_io_pkg;

    localparam int ST_TX_NOT_FULL = 0;
    localparam int ST_RX_VALID    = 1;
    localparam int ST_RX_OVR      = 2;
    localparam int ST_TX_IDLE     = 3;

    localparam int TX_AW_DEFAULT  = 4;

    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with 2**AW entries; push is refused when full at cycle start,
// pop is ignored when empty. rdata is the head entry, forced to zero when empty.
module uart_tx_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    wdata,
    output logic          full,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int          NUM      = 2 ** AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem [NUM];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Gating on empty keeps the head byte at zero after reset without clearing storage.
    assign rdata   = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// CPU-side UART controller: TX FIFO, single-byte RX holder with overrun tracking,
// and status word. Optional saturating overrun counter under UART_IO_OVR_COUNT_EN.
module uart_io_ctrl
    import uart_io_pkg::*;
#(
    parameter int TX_AW = TX_AW_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_rd,
    output logic [7:0] cpu_rdata,
    input  logic       stat_clr,
    output logic [3:0] status,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       tx_busy,
    input  logic       rx_strobe,
    input  logic [7:0] rx_data,
    output logic [7:0] ovr_count
);

    logic            fifo_full;
    logic            fifo_empty;
    logic [TX_AW:0]  fifo_count;
    rx_state_e       rx_state_q;
    rx_state_e       rx_state_d;
    logic            rx_load;
    logic            ovr_evt;
    logic            rx_overrun_q;

    uart_tx_fifo #(.AW(TX_AW)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cpu_wr),
        .wdata (cpu_wdata),
        .full  (fifo_full),
        .pop   (tx_ready),
        .rdata (tx_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_valid = !fifo_empty;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_load    = 1'b0;
        ovr_evt    = 1'b0;
        unique case (rx_state_q)
            RX_EMPTY: begin
                if (rx_strobe) begin
                    rx_load    = 1'b1;
                    rx_state_d = RX_FULL;
                end
            end
            RX_FULL: begin
                // A read in the same cycle frees the slot, so the new byte is taken.
                if (rx_strobe && cpu_rd) begin
                    rx_load = 1'b1;
                end else if (rx_strobe) begin
                    ovr_evt = 1'b1;
                end else if (cpu_rd) begin
                    rx_state_d = RX_EMPTY;
                end
            end
            default: rx_state_d = RX_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q   <= RX_EMPTY;
            cpu_rdata    <= 8'h00;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            if (rx_load) cpu_rdata <= rx_data;
            if (ovr_evt) begin
                rx_overrun_q <= 1'b1;
            end else if (stat_clr) begin
                rx_overrun_q <= 1'b0;
            end
        end
    end

`ifdef UART_IO_OVR_COUNT_EN
    logic [7:0] ovr_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_cnt_q <= 8'd0;
        end else if (ovr_evt) begin
            ovr_cnt_q <= stat_clr ? 8'd1 : sat_inc8(ovr_cnt_q);
        end else if (stat_clr) begin
            ovr_cnt_q <= 8'd0;
        end
    end

    assign ovr_count = ovr_cnt_q;
`else
    assign ovr_count = 8'd0;
`endif

    always_comb begin
        status                 = 4'b0000;
        status[ST_TX_NOT_FULL] = !fifo_full;
        status[ST_RX_VALID]    = (rx_state_q == RX_FULL);
        status[ST_RX_OVR]      = rx_overrun_q;
        status[ST_TX_IDLE]     = (fifo_count == '0) && !tx_busy;
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Testbench for uart_io_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_uart_io_ctrl;

    localparam int DEPTH = 16;
`ifdef UART_IO_OVR_COUNT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_wr;
    logic [7:0] cpu_wdata;
    logic       cpu_rd;
    logic [7:0] cpu_rdata;
    logic       stat_clr;
    logic [3:0] status;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       rx_strobe;
    logic [7:0] rx_data;
    logic [7:0] ovr_count;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [7:0] mq[$];
    bit         m_rx_full;
    logic [7:0] m_held;
    bit         m_ovr;
    int         m_cnt;
    bit         ff_seen;

    always #5 clk = ~clk;

    uart_io_ctrl #(.TX_AW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_wr    (cpu_wr),
        .cpu_wdata (cpu_wdata),
        .cpu_rd    (cpu_rd),
        .cpu_rdata (cpu_rdata),
        .stat_clr  (stat_clr),
        .status    (status),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .rx_strobe (rx_strobe),
        .rx_data   (rx_data),
        .ovr_count (ovr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [3:0] exp_st;
        exp_st[0] = (mq.size() != DEPTH);
        exp_st[1] = m_rx_full;
        exp_st[2] = m_ovr;
        exp_st[3] = (mq.size() == 0) && !tx_busy;
        chk("m_tx_valid", 32'(tx_valid), 32'(mq.size() != 0));
        chk("m_tx_data", 32'(tx_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        chk("m_status", 32'(status), 32'(exp_st));
        chk("m_cpu_rdata", 32'(cpu_rdata), 32'(m_held));
        chk("m_ovr_count", 32'(ovr_count), FEAT ? 32'(m_cnt) : 32'd0);
    endtask

    task automatic model_update();
        bit was_full;
        bit ovr_evt;
        if (reset) begin
            mq.delete();
            m_rx_full = 1'b0;
            m_held    = 8'h00;
            m_ovr     = 1'b0;
            m_cnt     = 0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        if (mq.size() != 0 && tx_ready) begin
            if (mq[0] == 8'hFF) ff_seen = 1'b1;
            void'(mq.pop_front());
        end
        if (cpu_wr && !was_full) mq.push_back(cpu_wdata);
        ovr_evt = m_rx_full && rx_strobe && !cpu_rd;
        if (rx_strobe && (!m_rx_full || cpu_rd)) begin
            m_held    = rx_data;
            m_rx_full = 1'b1;
        end else if (cpu_rd && m_rx_full) begin
            m_rx_full = 1'b0;
        end
        if (ovr_evt)       m_ovr = 1'b1;
        else if (stat_clr) m_ovr = 1'b0;
        if (ovr_evt)       m_cnt = stat_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        else if (stat_clr) m_cnt = 0;
    endtask

    // One clock: compare at the falling edge, advance model at the rising edge,
    // then drop the one-cycle strobes.
    task automatic cyc();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
        reset     = 1'b0;
        cpu_wr    = 1'b0;
        cpu_rd    = 1'b0;
        stat_clr  = 1'b0;
        rx_strobe = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cpu_wr = 1'b0; cpu_wdata = 8'h00; cpu_rd = 1'b0;
        stat_clr = 1'b0; tx_ready = 1'b0; tx_busy = 1'b0; rx_strobe = 1'b0; rx_data = 8'h00;
        m_rx_full = 1'b0; m_held = 8'h00; m_ovr = 1'b0; m_cnt = 0; ff_seen = 1'b0;
        @(posedge clk); #1;
        model_update();
        reset = 1'b0;
        cyc();

        // reset state
        chk("rst_status", 32'(status), 32'h9);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h00);
        chk("rst_ovr_count", 32'(ovr_count), 32'd0);

        // fill the FIFO with the core stalled, then try one more
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            cpu_wr = 1'b1; cpu_wdata = 8'h41 + 8'(i);
            cyc();
        end
        chk("full_not_full_bit", 32'(status[0]), 32'd0);
        cpu_wr = 1'b1; cpu_wdata = 8'hFF;
        cyc();
        chk("full_drop_still_full", 32'(status[0]), 32'd0);
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 32'(tx_data), 32'h41 + 32'(i));
            cyc();
        end
        chk("drain_empty", 32'(tx_valid), 32'd0);
        chk("drain_no_ff", 32'(ff_seen), 32'd0);

        // single byte through an empty FIFO with the core ready
        cpu_wr = 1'b1; cpu_wdata = 8'h55; tx_busy = 1'b1;
        cyc();
        chk("pt_valid", 32'(tx_valid), 32'd1);
        chk("pt_data", 32'(tx_data), 32'h55);
        cyc();
        chk("pt_popped", 32'(tx_valid), 32'd0);
        chk("pt_busy_not_idle", 32'(status[3]), 32'd0);
        tx_busy = 1'b0;
        #1;
        chk("pt_idle", 32'(status[3]), 32'd1);
        cyc();

        // overrun then clear
        rx_strobe = 1'b1; rx_data = 8'h10;
        cyc();
        rx_strobe = 1'b1; rx_data = 8'h20;
        cyc();
        chk("ovr_rdata", 32'(cpu_rdata), 32'h10);
        chk("ovr_flag", 32'(status[2]), 32'd1);
        chk("ovr_cnt", 32'(ovr_count), FEAT ? 32'd1 : 32'd0);
        stat_clr = 1'b1;
        cyc();
        chk("clr_flag", 32'(status[2]), 32'd0);
        chk("clr_cnt", 32'(ovr_count), 32'd0);

        // read and new byte together
        cpu_rd = 1'b1;
        cyc();
        rx_strobe = 1'b1; rx_data = 8'h30;
        cyc();
        cpu_rd = 1'b1; rx_strobe = 1'b1; rx_data = 8'h31;
        cyc();
        chk("rdwr_rdata", 32'(cpu_rdata), 32'h31);
        chk("rdwr_valid", 32'(status[1]), 32'd1);
        chk("rdwr_no_ovr", 32'(status[2]), 32'd0);

        // saturation
        for (int i = 0; i < 300; i++) begin
            rx_strobe = 1'b1; rx_data = 8'(i);
            cyc();
        end
        chk("sat_cnt", 32'(ovr_count), FEAT ? 32'd255 : 32'd0);
        chk("sat_rdata", 32'(cpu_rdata), 32'h31);

        // reset in the middle of traffic
        tx_ready = 1'b0;
        cpu_wr = 1'b1; cpu_wdata = 8'hA5;
        cyc();
        reset = 1'b1; cpu_wr = 1'b1; rx_strobe = 1'b1; stat_clr = 1'b1;
        cyc();
        chk("mid_rst_status", 32'(status), 32'h9);
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_data", 32'(tx_data), 32'h00);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 199) == 0);
            cpu_wr    = ($urandom_range(0, 1) == 1);
            cpu_wdata = 8'($urandom);
            cpu_rd    = ($urandom_range(0, 3) == 0);
            stat_clr  = ($urandom_range(0, 15) == 0);
            rx_strobe = ($urandom_range(0, 2) == 0);
            rx_data   = 8'($urandom);
            tx_ready  = ($urandom_range(0, 2) == 0);
            tx_busy   = ($urandom_range(0, 3) == 0);
            cyc();
        end
        @(negedge clk);
        model_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
